// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO.
// Ports: clk, reset, op[3:0], a, b, req -> busy, md_stall, md_out, hi, lo.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] hi_tmp_q;
  logic [31:0] lo_tmp_q;
  logic        upd_q;

  logic        is_md;
  logic        is_wr;
  logic        start_eff;
  logic        wr_eff;
  logic        is_div;
  logic [63:0] smul_d;
  logic [63:0] umul_d;
  logic [31:0] div_b;
  logic [31:0] sq_d;
  logic [31:0] sr_d;
  logic [31:0] uq_d;
  logic [31:0] ur_d;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic        upd_d;
  logic [3:0]  cnt_d;

  always_comb begin
    is_md = (op >= OP_MULT) && (op <= OP_DIVU);
    is_wr = (op == OP_MTHI) || (op == OP_MTLO);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
    start_eff = is_md & ~req & ~busy_q;
    wr_eff = is_wr & ~req & ~busy_q;

    smul_d = $signed({{32{a[31]}}, a})
           * $signed({{32{b[31]}}, b});
    umul_d = {32'd0, a} * {32'd0, b};

    // Divisor forced to 1 for b==0 (result discarded)
    // and for 0x80000000/-1, where a/1 is the
    // architectural answer (q=a, r=0).
    div_b = b;
    if (b == 32'd0) begin
      div_b = 32'd1;
    end else if (op == OP_DIV
              && a == 32'h8000_0000
              && b == 32'hFFFF_FFFF) begin
      div_b = 32'd1;
    end
    sq_d = $signed(a) / $signed(div_b);
    sr_d = $signed(a) % $signed(div_b);
    uq_d = a / div_b;
    ur_d = a % div_b;

    hi_d = 32'd0;
    lo_d = 32'd0;
    case (op)
      OP_MULT:  {hi_d, lo_d} = smul_d;
      OP_MULTU: {hi_d, lo_d} = umul_d;
      OP_DIV:   {hi_d, lo_d} = {sr_d, sq_d};
      OP_DIVU:  {hi_d, lo_d} = {ur_d, uq_d};
      default:  {hi_d, lo_d} = 64'd0;
    endcase

    upd_d = ~(is_div && (b == 32'd0));
    cnt_d = is_div ? 4'(DIV_CYCLES)
                   : 4'(MULT_CYCLES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
      upd_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_eff) begin
            hi_tmp_q <= hi_d;
            lo_tmp_q <= lo_d;
            upd_q    <= upd_d;
            cnt_q    <= cnt_d;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else if (wr_eff) begin
            if (op == OP_MTHI) hi_q <= a;
            else               lo_q <= a;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (upd_q) begin
              hi_q <= hi_tmp_q;
              lo_q <= lo_tmp_q;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign md_stall = start_eff | busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_out   = (op == OP_MFHI) ? hi_q :
                    (op == OP_MFLO) ? lo_q :
                    32'd0;

endmodule
